rainbow_color_gen: RTL and testbench
====================================

Name: rainbow_color_gen

Overview:
- Upstream colour source for the WS2812 serializer.
- Produces one 8-bit G/R/B triple per LED position along the strip. Colour is a fully saturated HSV hue wheel: each LED is offset in hue from the previous one, and the whole pattern advances in hue every N frames.
- Applies a global brightness scale.
- Tracks LED position from two strobes supplied by the serializer: end-of-pause (frame_start) and per-LED boundary (led_next).

Parameters:
- LEDS, 8: LEDs per frame; led_index wraps at LEDS-1.
- HUE_STEP_LED, 192: hue increment between adjacent LEDs. Legal range 0..1535.
- HUE_STEP_FRAME, 8: base hue increment per frame step. Legal range 0..1535.
- FRAMES_PER_STEP, 1: number of frame_start pulses per base hue advance. Must be at least 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- frame_start, input, 1: one-cycle pulse at the start of each frame.
- led_next, input, 1: one-cycle pulse when the current LED's 24 bits have been consumed.
- brightness, input, 8: global intensity; 255 means full scale.
- r, output, 8: red component for the current LED.
- g, output, 8: green component for the current LED.
- b, output, 8: blue component for the current LED.
- led_index, output, 5: index of the LED whose colour is being generated.
- valid, output, 1: r/g/b reflect the current led_hue.

Behaviour:
- Hue domain is 0..1535, held in 11 bits.
  - hue[10:8] is the sector (0..5); hue[7:0] is frac.
  - All hue additions are done at 12 bits; if the sum is ≥1536, subtract 1536.
- Reset values: base_hue 0, frame_cnt 0, led_hue 0, led_index 0, all pipeline registers 0, r/g/b 0, valid 0.
- Frame step:
  - On frame_start, if frame_cnt == FRAMES_PER_STEP-1: frame_cnt <= 0 and base_hue <= base_hue + HUE_STEP_FRAME (mod 1536).
  - Otherwise frame_cnt increments.
- LED tracking, in priority order:
  1. rst.
  2. frame_start: led_index <= 0; led_hue <= the base_hue value being written this cycle (the post-update value).
  3. led_next with led_index == LEDS-1: led_index <= 0; led_hue <= base_hue.
  4. led_next otherwise: led_index + 1; led_hue <= led_hue + HUE_STEP_LED (mod 1536).
- Simultaneous frame_start and led_next: frame_start wins and led_next is ignored.
- Pipeline stage 1 (registered): computes c_r/c_g/c_b from led_hue and registers brightness. With rise = frac and fall = 255-frac:
  - Sector 0: (R,G,B) = (255, rise, 0).
  - Sector 1: (fall, 255, 0).
  - Sector 2: (0, 255, rise).
  - Sector 3: (0, fall, 255).
  - Sector 4: (rise, 0, 255).
  - Sector 5: (255, 0, fall).
- Pipeline stage 2 (registered): each output = (c × (brightness_q + 1)) >> 8, using a 17-bit product and keeping the upper 8 bits.
- Latency: a led_hue update at edge N appears on r/g/b at edge N+2.
- led_index output is the tracking register itself; it is not delayed.
- Timing contract: the serializer issues led_next at least 3 clk before it samples the first bit of the next LED. r/g/b are stable between updates.
- valid: 0 during reset and for the first two cycles after rst deasserts; 1 thereafter until the next reset.
- Reset mid-frame: all state returns to the reset values on the next edge; no partial frame state is retained.
- Idle (no strobes): all outputs hold; brightness changes propagate to r/g/b in 2 cycles.

Test Plan:
1. Reset, brightness=255, no strobes -> valid=1 on the 2nd cycle after rst falls; (r,g,b)=(255,0,0); led_index=0.
2. Eight led_next pulses, 4 cycles apart, defaults:
   - LED1: hue 192 -> (255,192,0).
   - LED2: hue 384 -> (127,255,0).
   - LED3: hue 576 -> (0,255,64).
   - After the 8th pulse: led_index=0, hue 0 -> (255,0,0).
3. frame_start once -> base_hue=8, led_hue=8 -> (255,8,0). After 192 frame_starts total -> base_hue wraps to 0 -> (255,0,0). With FRAMES_PER_STEP=4, base_hue advances only on every 4th pulse.
4. Brightness at hue 0:
   - brightness=128 -> r=128, g=0, b=0.
   - brightness=0 -> (0,0,0).
   - brightness change is visible exactly 2 cycles later.
5. frame_start and led_next in the same cycle, with led_index=3 -> led_index=0, led_hue=updated base_hue; no increment to 4.
6. rst asserted for 1 cycle with led_index=5, base_hue=40 -> next cycle: led_index=0, base_hue=0, valid=0, r/g/b=0; valid returns after 2 cycles with (255,0,0).

Source files
------------

// File: rtl/rainbow_color_gen_if.sv
// Colour bus between the rainbow generator and the WS2812 serializer.
// The master is the serializer side; the slave is the generator.
interface rainbow_color_gen_if;
   logic       frame_start;
   logic       led_next;
   logic [7:0] brightness;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic [4:0] led_index;
   logic       valid;

   modport master (
      output frame_start, led_next, brightness,
      input  r, g, b, led_index, valid
   );

   modport slave (
      input  frame_start, led_next, brightness,
      output r, g, b, led_index, valid
   );
endinterface

// File: rtl/rainbow_color_gen.sv
// Saturated HSV hue-wheel colour source, one G/R/B triple per LED,
// with per-LED and per-frame hue offsets and global brightness.
module rainbow_color_gen #(
   parameter int LEDS            = 8,
   parameter int HUE_STEP_LED    = 192,
   parameter int HUE_STEP_FRAME  = 8,
   parameter int FRAMES_PER_STEP = 1
) (
   input logic               clk,
   input logic               rst,
   rainbow_color_gen_if.slave bus
);
   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   function automatic logic [10:0] hue_add(
      input logic [10:0] a,
      input logic [10:0] s
   );
      logic [11:0] t;
      t = {1'b0, a} + {1'b0, s};
      if (t >= 12'd1536) t = t - 12'd1536;
      return t[10:0];
   endfunction

   function automatic logic [7:0] scale(
      input logic [7:0] c,
      input logic [7:0] br
   );
      logic [16:0] p;
      p = 17'(c) * (17'(br) + 17'd1);
      return p[15:8];
   endfunction

   logic [FW-1:0] frame_cnt;
   logic [10:0]   base_hue;
   logic [10:0]   base_nxt;
   logic [10:0]   led_hue;
   logic          step;

   assign step = bus.frame_start &&
                 (frame_cnt == FW'(FRAMES_PER_STEP - 1));
   assign base_nxt = step ?
                     hue_add(base_hue, 11'(HUE_STEP_FRAME)) :
                     base_hue;

   // frame_start outranks led_next; the new LED 0 hue is post-step
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt     <= '0;
         base_hue      <= '0;
         led_hue       <= '0;
         bus.led_index <= '0;
      end else if (bus.frame_start) begin
         frame_cnt     <= step ? '0 : frame_cnt + FW'(1);
         base_hue      <= base_nxt;
         led_hue       <= base_nxt;
         bus.led_index <= '0;
      end else if (bus.led_next) begin
         if (bus.led_index == 5'(LEDS - 1)) begin
            bus.led_index <= '0;
            led_hue       <= base_hue;
         end else begin
            bus.led_index <= bus.led_index + 5'd1;
            led_hue       <= hue_add(led_hue, 11'(HUE_STEP_LED));
         end
      end
   end

   logic [2:0] sec;
   logic [7:0] rise;
   logic [7:0] fall;
   logic [7:0] nr, ng, nb;

   assign sec  = led_hue[10:8];
   assign rise = led_hue[7:0];
   assign fall = 8'd255 - rise;

   always_comb begin
      nr = '0;
      ng = '0;
      nb = '0;
      unique case (sec)
         3'd0: begin nr = 8'd255; ng = rise;   end
         3'd1: begin nr = fall;   ng = 8'd255; end
         3'd2: begin ng = 8'd255; nb = rise;   end
         3'd3: begin ng = fall;   nb = 8'd255; end
         3'd4: begin nr = rise;   nb = 8'd255; end
         3'd5: begin nr = 8'd255; nb = fall;   end
         default: ;
      endcase
   end

   logic [7:0] c_r, c_g, c_b;
   logic [7:0] br_q;
   logic       v1;

   always_ff @(posedge clk) begin
      if (rst) begin
         c_r       <= '0;
         c_g       <= '0;
         c_b       <= '0;
         br_q      <= '0;
         bus.r     <= '0;
         bus.g     <= '0;
         bus.b     <= '0;
         v1        <= 1'b0;
         bus.valid <= 1'b0;
      end else begin
         c_r       <= nr;
         c_g       <= ng;
         c_b       <= nb;
         br_q      <= bus.brightness;
         bus.r     <= scale(c_r, br_q);
         bus.g     <= scale(c_g, br_q);
         bus.b     <= scale(c_b, br_q);
         v1        <= 1'b1;
         bus.valid <= v1;
      end
   end
endmodule

// File: tb/tb_rainbow_color_gen.sv
// Directed and random checks of rainbow_color_gen against a hue model,
// with two instances (one and four frames per hue step).
module tb_rainbow_color_gen;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fs  = 1'b0;
   logic       ln  = 1'b0;
   logic [7:0] br  = 8'd255;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rainbow_color_gen_if if0 ();
   rainbow_color_gen_if if1 ();

   assign if0.frame_start = fs;
   assign if0.led_next    = ln;
   assign if0.brightness  = br;
   assign if1.frame_start = fs;
   assign if1.led_next    = ln;
   assign if1.brightness  = br;

   rainbow_color_gen #(.FRAMES_PER_STEP(1)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );
   rainbow_color_gen #(.FRAMES_PER_STEP(4)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   int nfs  = 0;
   int idx  = 0;
   int vcnt = 0;
   int s1b  = 0;
   logic [23:0] s1c  [2];
   logic [23:0] outc [2];
   int fps [2] = '{1, 4};

   function automatic int hue_of(input int f);
      int base;
      base = ((nfs / f) * 8) % 1536;
      return (base + idx * 192) % 1536;
   endfunction

   function automatic logic [23:0] colour(input int h);
      int s, up, dn;
      s  = h / 256;
      up = h % 256;
      dn = 255 - up;
      case (s)
         0: return {8'(255), 8'(up), 8'(0)};
         1: return {8'(dn), 8'(255), 8'(0)};
         2: return {8'(0), 8'(255), 8'(up)};
         3: return {8'(0), 8'(dn), 8'(255)};
         4: return {8'(up), 8'(0), 8'(255)};
         default: return {8'(255), 8'(0), 8'(dn)};
      endcase
   endfunction

   function automatic logic [23:0] dim(input logic [23:0] c, input int k);
      int rr, gg, bb;
      rr = (int'(c[23:16]) * (k + 1)) / 256;
      gg = (int'(c[15:8]) * (k + 1)) / 256;
      bb = (int'(c[7:0]) * (k + 1)) / 256;
      return {8'(rr), 8'(gg), 8'(bb)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         nfs = 0; idx = 0; vcnt = 0; s1b = 0;
         for (int k = 0; k < 2; k++) begin
            s1c[k] = '0; outc[k] = '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            outc[k] = dim(s1c[k], s1b);
            s1c[k]  = colour(hue_of(fps[k]));
         end
         s1b = int'(br);
         if (fs) begin
            nfs++; idx = 0;
         end else if (ln) begin
            idx = (idx == 7) ? 0 : idx + 1;
         end
         if (vcnt < 2) vcnt++;
      end
      #1;
      chk("rgb0", {8'h0, if0.r, if0.g, if0.b}, {8'h0, outc[0]});
      chk("rgb1", {8'h0, if1.r, if1.g, if1.b}, {8'h0, outc[1]});
      chk("idx0", 32'(if0.led_index), 32'(idx));
      chk("idx1", 32'(if1.led_index), 32'(idx));
      chk("vld0", 32'(if0.valid), 32'(vcnt >= 2));
      chk("vld1", 32'(if1.valid), 32'(vcnt >= 2));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_ln(input int gap);
      ln = 1'b1; tick(); ln = 1'b0; ticks(gap);
   endtask

   task automatic pulse_fs(input int gap);
      fs = 1'b1; tick(); fs = 1'b0; ticks(gap);
   endtask

   function automatic logic [31:0] rgb(input int rr, input int gg,
                                       input int bb);
      return {8'h0, 8'(rr), 8'(gg), 8'(bb)};
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         s1c[k] = '0; outc[k] = '0;
      end
      ticks(2);
      rst = 1'b0;
      tick();
      chk("valid_1st", 32'(if0.valid), 32'd0);
      tick();
      chk("valid_2nd", 32'(if0.valid), 32'd1);
      chk("reset_red", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 0, 0));

      pulse_ln(3);
      chk("led1", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 192, 0));
      pulse_ln(3);
      chk("led2", {8'h0, if0.r, if0.g, if0.b}, rgb(127, 255, 0));
      pulse_ln(3);
      chk("led3", {8'h0, if0.r, if0.g, if0.b}, rgb(0, 255, 64));
      for (int i = 0; i < 5; i++) pulse_ln(3);
      chk("wrap_idx", 32'(if0.led_index), 32'd0);
      chk("wrap_rgb", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 0, 0));

      pulse_fs(3);
      chk("fs1", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 8, 0));
      chk("fs1_div4", {8'h0, if1.r, if1.g, if1.b}, rgb(255, 0, 0));
      for (int i = 0; i < 3; i++) pulse_fs(1);
      ticks(2);
      chk("fs4_div4", {8'h0, if1.r, if1.g, if1.b}, rgb(255, 8, 0));
      for (int i = 0; i < 188; i++) pulse_fs(1);
      ticks(2);
      chk("fs192", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 0, 0));
      chk("fs192_div4", {8'h0, if1.r, if1.g, if1.b}, rgb(127, 255, 0));

      br = 8'd128;
      tick();
      chk("br_hold", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 0, 0));
      tick();
      chk("br128", {8'h0, if0.r, if0.g, if0.b}, rgb(128, 0, 0));
      br = 8'd0;
      ticks(2);
      chk("br0", {8'h0, if0.r, if0.g, if0.b}, rgb(0, 0, 0));
      br = 8'd255;
      ticks(2);

      for (int i = 0; i < 3; i++) pulse_ln(1);
      chk("idx3", 32'(if0.led_index), 32'd3);
      fs = 1'b1; ln = 1'b1;
      tick();
      fs = 1'b0; ln = 1'b0;
      chk("both_idx", 32'(if0.led_index), 32'd0);
      ticks(2);
      chk("both_rgb", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 8, 0));

      for (int i = 0; i < 4; i++) pulse_fs(1);
      ticks(2);
      chk("base40", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 40, 0));
      for (int i = 0; i < 5; i++) pulse_ln(1);
      chk("idx5", 32'(if0.led_index), 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_idx", 32'(if0.led_index), 32'd0);
      chk("rst_vld", 32'(if0.valid), 32'd0);
      chk("rst_rgb", {8'h0, if0.r, if0.g, if0.b}, rgb(0, 0, 0));
      ticks(2);
      chk("rst_back_vld", 32'(if0.valid), 32'd1);
      chk("rst_back_rgb", {8'h0, if0.r, if0.g, if0.b}, rgb(255, 0, 0));

      for (int i = 0; i < 600; i++) begin
         fs  = ($urandom_range(7) == 0);
         ln  = ($urandom_range(3) == 0);
         rst = ($urandom_range(149) == 0);
         if ($urandom_range(15) == 0) br = 8'($urandom);
         tick();
      end
      fs = 1'b0; ln = 1'b0; rst = 1'b0;
      ticks(3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
